// File: rtl/quad_pkg.sv
// Shared types and constants for the SIA/SIB quadrature pulse generator.
package quad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PH1,
        PH2,
        PH3,
        PH4,
        GAPW,
        FIN
    } state_t;

    localparam int unsigned QUARTER_DEF = 4;
    localparam int unsigned GAP_DEF     = 0;

    // {SIA,SIB} after each of the four transitions of one detent
    localparam logic [1:0] PAT_RIGHT [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    localparam logic [1:0] PAT_LEFT  [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

    function automatic logic [1:0] phase_pat(input logic dir, input logic [1:0] idx);
        return dir ? PAT_LEFT[idx] : PAT_RIGHT[idx];
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter; tc is high during the last clock of a loaded interval.
module phase_timer #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Loading L on an edge makes tc high on the cycle before edge +L
    assign tc = (cnt == W'(1));

endmodule

// File: rtl/quad_pulse_gen.sv
// Quadrature pulse generator: emits COUNT detents on SIA/SIB in direction DIR.
module quad_pulse_gen
    import quad_pkg::*;
#(
    parameter int unsigned QUARTER = QUARTER_DEF,
    parameter int unsigned GAP     = GAP_DEF,
    parameter int unsigned CW      = 7
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          START,
    input  logic          DIR,
    input  logic [CW-1:0] COUNT,
    input  logic          ABORT,
    output logic          SIA,
    output logic          SIB,
    output logic          BUSY,
    output logic          DONE,
    output logic [CW-1:0] SENT
);

    localparam int unsigned TMAX = (QUARTER > GAP) ? QUARTER : GAP;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    state_t        state;
    logic          dir_q;
    logic [CW-1:0] count_q;
    logic          abort_q;

    logic          tc;
    logic          tload;
    logic [TW-1:0] tval;
    logic          last;

    always_comb begin
        tload = ((state == IDLE) && START && (COUNT != '0))
              || (tc && (state inside {PH1, PH2, PH3, PH4, GAPW}));
        tval  = ((state == PH4) && (GAP != 0)) ? TW'(GAP) : TW'(QUARTER);
        // ABORT is also honoured on the decision edge itself, not only once latched
        last  = (SENT == count_q) || abort_q || ABORT;
    end

    phase_timer #(
        .W(TW)
    ) u_timer (
        .clk     (CLK),
        .rst_n   (RST_N),
        .load    (tload),
        .load_val(tval),
        .tc      (tc)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            SIA     <= 1'b0;
            SIB     <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            SENT    <= '0;
            dir_q   <= 1'b0;
            count_q <= '0;
            abort_q <= 1'b0;
        end else begin
            if ((state != IDLE) && ABORT) begin
                abort_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        dir_q   <= DIR;
                        count_q <= COUNT;
                        abort_q <= 1'b0;
                        BUSY    <= 1'b1;
                        SENT    <= '0;
                        if (COUNT != '0) begin
                            {SIA, SIB} <= phase_pat(DIR, 2'd0);
                            state      <= PH1;
                        end else begin
                            state <= FIN;
                        end
                    end
                end
                PH1: if (tc) begin
                    {SIA, SIB} <= phase_pat(dir_q, 2'd1);
                    state      <= PH2;
                end
                PH2: if (tc) begin
                    {SIA, SIB} <= phase_pat(dir_q, 2'd2);
                    state      <= PH3;
                end
                PH3: if (tc) begin
                    {SIA, SIB} <= phase_pat(dir_q, 2'd3);
                    SENT       <= SENT + 1'b1;
                    state      <= PH4;
                end
                PH4, GAPW: if (tc) begin
                    if ((state == PH4) && (GAP != 0)) begin
                        state <= GAPW;
                    end else if (last) begin
                        state <= FIN;
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                    end else begin
                        {SIA, SIB} <= phase_pat(dir_q, 2'd0);
                        state      <= PH1;
                    end
                end
                FIN: begin
                    // COUNT=0 arrives here with DONE low and spends one busy cycle first
                    if (DONE) begin
                        DONE  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        DONE <= 1'b1;
                        BUSY <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_quad_pulse_gen.sv
// Bench for quad_pulse_gen: two instances (GAP=0 and GAP=3) share stimulus, checked per cycle.
module tb_quad_pulse_gen;

    typedef struct packed {
        logic       sia;
        logic       sib;
        logic       busy;
        logic       done;
        logic [6:0] sent;
    } obs_t;

    logic       CLK = 1'b0;
    logic       RST_N, START, DIR, ABORT;
    logic [6:0] COUNT;
    logic       sia0, sib0, busy0, done0;
    logic       sia1, sib1, busy1, done1;
    logic [6:0] sent0, sent1;

    int   checks = 0;
    int   failures = 0;
    logic exp_dir = 1'b0;
    logic [1:0] prev0 = 2'b00, prev1 = 2'b00;
    int   dec0 = 0, dec1 = 0;

    quad_pulse_gen #(.QUARTER(2), .GAP(0), .CW(7)) u_dut0 (
        .CLK(CLK), .RST_N(RST_N), .START(START), .DIR(DIR), .COUNT(COUNT), .ABORT(ABORT),
        .SIA(sia0), .SIB(sib0), .BUSY(busy0), .DONE(done0), .SENT(sent0)
    );

    quad_pulse_gen #(.QUARTER(2), .GAP(3), .CW(7)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N), .START(START), .DIR(DIR), .COUNT(COUNT), .ABORT(ABORT),
        .SIA(sia1), .SIB(sib1), .BUSY(busy1), .DONE(done1), .SENT(sent1)
    );

    always #5 CLK = ~CLK;

    function automatic logic [1:0] line_pat(input logic dir, input int ph);
        case (ph)
            0:       return dir ? 2'b01 : 2'b10;
            1:       return 2'b11;
            2:       return dir ? 2'b10 : 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic int detents_done(input int q, input int g, input int n, input int a);
        int p = 4 * q + g;
        int ne = n;
        if (a > 0 && n > 0) begin
            ne = (a + p - 1) / p;
            if (ne > n) ne = n;
        end
        return ne;
    endfunction

    function automatic int done_at(input int q, input int g, input int n, input int a);
        return (n == 0) ? 1 : detents_done(q, g, n, a) * (4 * q + g);
    endfunction

    // Expected outputs t clocks after the accepting edge; a = edge offset where ABORT is first seen
    function automatic obs_t model(input int q, input int g, input logic dir,
                                   input int n, input int a, input int t);
        int p = 4 * q + g;
        int d = done_at(q, g, n, a);
        int r;
        obs_t o = '0;
        if (t < d) begin
            o.busy = 1'b1;
            if (n > 0) begin
                r = t % p;
                {o.sia, o.sib} = line_pat(dir, r / q);
                o.sent = 7'((t / p) + ((r >= 3 * q) ? 1 : 0));
            end
        end else begin
            o.done = (t == d);
            o.sent = 7'(detents_done(q, g, n, a));
        end
        return o;
    endfunction

    task automatic step();
        logic [1:0] cur;
        @(posedge CLK);
        #1;
        cur = {sia0, sib0};
        if (cur != prev0) begin
            checks++;
            if ((cur ^ prev0) == 2'b11) begin
                failures++;
                $display("FAIL gray_dut0 got=%b prev=%b required one bit change", cur, prev0);
            end
        end
        if (!prev0[1] && cur[1]) begin
            checks++;
            if (cur[0] !== exp_dir) begin
                failures++;
                $display("FAIL sia_rise_dut0 got sib=%b required=%b", cur[0], exp_dir);
            end
            dec0 = cur[0] ? (dec0 + 99) % 100 : (dec0 + 1) % 100;
        end
        prev0 = cur;
        cur = {sia1, sib1};
        if (cur != prev1) begin
            checks++;
            if ((cur ^ prev1) == 2'b11) begin
                failures++;
                $display("FAIL gray_dut1 got=%b prev=%b required one bit change", cur, prev1);
            end
        end
        if (!prev1[1] && cur[1]) begin
            checks++;
            if (cur[0] !== exp_dir) begin
                failures++;
                $display("FAIL sia_rise_dut1 got sib=%b required=%b", cur[0], exp_dir);
            end
            dec1 = cur[0] ? (dec1 + 99) % 100 : (dec1 + 1) % 100;
        end
        prev1 = cur;
    endtask

    // rs > 0 re-pulses START (DIR=1, COUNT=7) while busy; it must be ignored
    task automatic run_txn(input logic dir, input int n, input int a, input int rs,
                           output int dt0, output int dt1);
        int   d0 = done_at(2, 0, n, a);
        int   d1 = done_at(2, 3, n, a);
        int   tmax = ((d0 > d1) ? d0 : d1) + 1;
        obs_t o, e;
        dt0 = -1;
        dt1 = -1;
        START   = 1'b1;
        DIR     = dir;
        COUNT   = 7'(n);
        ABORT   = 1'b0;
        exp_dir = dir;
        step();
        for (int t = 0; t <= tmax; t++) begin
            if (t > 0) begin
                ABORT = (t == a);
                START = (t == rs);
                if (t == rs) begin
                    DIR   = 1'b1;
                    COUNT = 7'd7;
                end else begin
                    DIR   = 1'($urandom);
                    COUNT = 7'($urandom_range(0, 99));
                end
                step();
            end
            o = {sia0, sib0, busy0, done0, sent0};
            e = model(2, 0, dir, n, a, t);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL txn_dut0 t=%0d got=%b required=%b (sia,sib,busy,done,sent)", t, o, e);
            end
            o = {sia1, sib1, busy1, done1, sent1};
            e = model(2, 3, dir, n, a, t);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL txn_dut1 t=%0d got=%b required=%b (sia,sib,busy,done,sent)", t, o, e);
            end
            if (done0 === 1'b1 && dt0 < 0) dt0 = t;
            if (done1 === 1'b1 && dt1 < 0) dt1 = t;
        end
        START = 1'b0;
        ABORT = 1'b0;
    endtask

    task automatic assert_reset(input string tag);
        obs_t o;
        o = {sia0, sib0, busy0, done0, sent0};
        checks++;
        if (o !== '0) begin
            failures++;
            $display("FAIL %s_dut0 got=%b required=0", tag, o);
        end
        o = {sia1, sib1, busy1, done1, sent1};
        checks++;
        if (o !== '0) begin
            failures++;
            $display("FAIL %s_dut1 got=%b required=0", tag, o);
        end
        prev0 = 2'b00;
        prev1 = 2'b00;
        dec0  = 0;
        dec1  = 0;
    endtask

    task automatic test_reset();
        #2 RST_N = 1'b0;
        #1 assert_reset("reset");
        @(posedge CLK);
        @(posedge CLK);
        #3 RST_N = 1'b1;
        step();
        assert_reset("post_reset");
    endtask

    task automatic test_basic();
        int dt0, dt1;
        run_txn(1'b0, 3, 0, 0, dt0, dt1);
        checks++;
        if (dt0 !== 24) begin
            failures++;
            $display("FAIL basic_done_dut0 got=%0d required=24", dt0);
        end
        checks++;
        if (dt1 !== 33) begin
            failures++;
            $display("FAIL basic_done_dut1 got=%0d required=33", dt1);
        end
    endtask

    task automatic test_count_zero();
        int dt0, dt1;
        run_txn(1'($urandom), 0, 0, 0, dt0, dt1);
        checks++;
        if (dt0 !== 1 || dt1 !== 1) begin
            failures++;
            $display("FAIL count_zero_done got=%0d/%0d required=1/1", dt0, dt1);
        end
    endtask

    task automatic test_abort();
        int dt0, dt1;
        // edge 16 is inside detent 2 PH3 for GAP=3 and the detent-2 boundary for GAP=0
        run_txn(1'b0, 5, 16, 0, dt0, dt1);
        checks++;
        if (dt1 !== 22 || sent1 !== 7'd2) begin
            failures++;
            $display("FAIL abort_dut1 got done_t=%0d sent=%0d required=22/2", dt1, sent1);
        end
        checks++;
        if (dt0 !== 16 || sent0 !== 7'd2) begin
            failures++;
            $display("FAIL abort_dut0 got done_t=%0d sent=%0d required=16/2", dt0, sent0);
        end
    endtask

    task automatic test_restart_ignored();
        int dt0, dt1;
        run_txn(1'b0, 3, 0, 5, dt0, dt1);
        checks++;
        if (dt0 !== 24) begin
            failures++;
            $display("FAIL restart_done_dut0 got=%0d required=24", dt0);
        end
    endtask

    task automatic test_reset_mid();
        START   = 1'b1;
        DIR     = 1'b0;
        COUNT   = 7'd3;
        exp_dir = 1'b0;
        step();
        START = 1'b0;
        repeat (3) step();
        checks++;
        if ({sia0, sib0} !== 2'b11) begin
            failures++;
            $display("FAIL reset_mid_ph2 got=%b required=11", {sia0, sib0});
        end
        #2 RST_N = 1'b0;
        #1 assert_reset("reset_mid");
        @(posedge CLK);
        #3 RST_N = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({busy0, done0, busy1, done1} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_mid_idle i=%0d got busy/done=%b required=0000",
                         i, {busy0, done0, busy1, done1});
            end
        end
    endtask

    task automatic test_loopback();
        int dt0, dt1;
        int dirs [3] = '{0, 1, 0};
        int ns   [3] = '{12, 13, 1};
        int exps [3] = '{12, 99, 0};
        for (int i = 0; i < 3; i++) begin
            run_txn(1'(dirs[i]), ns[i], 0, 0, dt0, dt1);
            checks++;
            if (dec0 !== exps[i] || dec1 !== exps[i]) begin
                failures++;
                $display("FAIL loopback_%0d got=%0d/%0d required=%0d", i, dec0, dec1, exps[i]);
            end
        end
    endtask

    task automatic test_random();
        int dt0, dt1, n, a, dmax;
        for (int i = 0; i < 8; i++) begin
            n    = $urandom_range(0, 6);
            dmax = done_at(2, 3, n, 0);
            a    = ($urandom_range(0, 1) == 1) ? $urandom_range(1, dmax + 2) : 0;
            run_txn(1'($urandom), n, a, 0, dt0, dt1);
        end
    endtask

    initial begin
        RST_N = 1'b1;
        START = 1'b0;
        DIR   = 1'b0;
        ABORT = 1'b0;
        COUNT = '0;
        test_reset();
        test_basic();
        test_count_zero();
        test_abort();
        test_restart_ignored();
        test_reset_mid();
        test_loopback();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/quad_pulse_gen.md
Name: quad_pulse_gen

Overview:
Synthesizable quadrature pulse generator: the transmit side of the SIA/SIB impulse interface consumed by the Mod100 impulse counter block.
- On command, emits N complete detents in the requested direction on SIA/SIB, then signals completion.
- Drives the counter in simulation benches and in a hardware loopback self-test.

Parameters:
QUARTER, 4, clocks per quadrature phase (>=1); spacing between consecutive line transitions.
GAP, 0, extra idle clocks with SIA=SIB=0 appended after each detent (>=0).
CW, 7, width of COUNT and SENT; supports 0..99 detents per command.

Ports:
CLK  input  1  system clock, rising edge.
RST_N  input  1  reset, asynchronous, active-low.
START  input  1  one-cycle command strobe; accepted only when BUSY=0.
DIR  input  1  0 = right/increment (SIB low at SIA rise), 1 = left/decrement (SIB high at SIA rise).
COUNT  input  CW  number of detents to emit; latched with START.
ABORT  input  1  stop after the detent in progress completes.
SIA  output  1  quadrature line A, registered.
SIB  output  1  quadrature line B, registered.
BUSY  output  1  high from START acceptance until DONE.
DONE  output  1  one-cycle completion pulse.
SENT  output  CW  completed detents of the current or last command.

Behaviour:
- Reset (RST_N=0, async): SIA=0, SIB=0, BUSY=0, DONE=0, SENT=0, state IDLE, timer cleared. Reset mid-detent drops both lines to 0 immediately; no completion pulse is generated.
- States: IDLE, PH1, PH2, PH3, PH4, GAPW, FIN.
- Line sequence per detent (values of SIA,SIB after each transition):
  - DIR=0: 10, 11, 01, 00 (A leads B).
  - DIR=1: 01, 11, 10, 00 (B leads A).
- Every detent starts and ends at SIA=SIB=0.
- Accept: on edge k with IDLE and START=1:
  - Latch DIR and COUNT; BUSY<=1; SENT<=0.
  - If COUNT>0, first transition (PH1 value) is registered on edge k.
- Timing: PH1 to PH4 each hold QUARTER clocks. After PH4, hold 00 for QUARTER clocks, then GAPW for GAP clocks (skipped if GAP=0). Each detent occupies 4*QUARTER+GAP clocks.
- SENT increments on the edge the PH4 value (00) is registered.
- Completion: FIN is entered when SENT reaches latched COUNT, or on ABORT. DONE=1 and BUSY=0 on edge k + N*(4*QUARTER+GAP). Next cycle returns to IDLE and DONE=0.
- COUNT=0: no line activity; BUSY high for one cycle; DONE on edge k+1.
- ABORT:
  - Sampled every cycle while BUSY, latched as a sticky flag.
  - The current detent always completes to 00; the next detent is never started.
  - DONE follows after the trailing QUARTER(+GAP) hold. SENT reports completed detents.
  - ABORT while IDLE is ignored.
- START while BUSY is ignored (no queueing). START and ABORT in the same IDLE cycle: START is accepted, and ABORT does not set the sticky flag.
- DIR/COUNT changes while BUSY have no effect.
- At most one of SIA/SIB changes per edge (Gray property), including across detent boundaries.

Decomposition:
- Package quad_pkg:
  - state enum (IDLE, PH1..PH4, GAPW, FIN);
  - 2-bit phase-pattern constants for DIR=0 and DIR=1;
  - QUARTER/GAP default constants.
- Sub-module phase_timer: loadable down-counter with a terminal-count pulse, sized $clog2(max(QUARTER,GAP)+1). The FSM loads it with QUARTER or GAP.

Test Plan:
1. Reset, QUARTER=2, GAP=0, START with DIR=0, COUNT=3 at edge k -> SIA,SIB = 10,11,01,00 repeated 3x, transitions every 2 clocks, DONE at k+24, SENT=3, BUSY low at k+24.
2. Loopback into the Mod100 counter from 00: right COUNT=12 -> counter 12; then left COUNT=13 -> counter 99 (wrap below zero); then right COUNT=1 -> 00.
3. COUNT=0 -> lines stay 00; DONE exactly one cycle after START; SENT=0.
4. QUARTER=2, GAP=3, COUNT=5, ABORT pulsed during detent 2 PH3 -> detent 2 finishes to 00, no third SIA edge, DONE 2+3 clocks after the 00 transition, SENT=2.
5. START re-pulsed while BUSY with DIR=1, COUNT=7 -> ignored, original waveform unchanged; RST_N low during PH2 -> SIA=SIB=0 and BUSY=0 asynchronously, no DONE.
6. Gray check across all runs: assertion that SIA and SIB never toggle on the same edge and that SIB at each SIA rising edge equals the latched DIR.
